// File: rtl/nor_bus_ctrl.sv
// nor_bus_ctrl: Wishbone slave to asynchronous NOR flash bus sequencer.
// Define NOR_BUS_CTRL_RYBY_WAIT_EN to wait on RY/BY# after each write.
module nor_bus_ctrl #(
  parameter int ADDRBITS       = 26,
  parameter int DATABITS       = 16,
  parameter int T_RD           = 8,
  parameter int T_WP           = 4,
  parameter int T_WH           = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic                wb_we_i,
  input  logic [ADDRBITS-1:0] wb_adr_i,
  input  logic [DATABITS-1:0] wb_dat_i,
  output logic [DATABITS-1:0] wb_dat_o,
  output logic                wb_ack_o,
  output logic                wb_err_o,
  output logic                wb_stall_o,
  output logic [ADDRBITS-1:0] flash_adr_o,
  output logic [DATABITS-1:0] flash_dq_o,
  output logic                flash_dq_oe_o,
  output logic                flash_ce_n_o,
  output logic                flash_oe_n_o,
  output logic                flash_we_n_o,
  input  logic [DATABITS-1:0] flash_dq_i,
  input  logic                flash_ry_by_i,
  output logic                busy_o
);
  typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, RDY_WAIT, RESP} state_t;
  state_t state, state_nxt;
  logic [31:0] cnt;
  logic we_q;
  logic err_q;
  logic accept;
  assign accept = wb_cyc_i && wb_stb_i && state == IDLE;
`ifdef NOR_BUS_CTRL_RYBY_WAIT_EN
  logic [1:0] ry_sync;
  logic ready_ok;
  assign ready_ok = cnt >= 32'd1 && ry_sync[1];
  always_ff @(posedge clk_i)
    if (reset_i) begin
      ry_sync <= 2'b11;
      err_q   <= 1'b0;
    end else begin
      ry_sync <= {ry_sync[0], flash_ry_by_i};
      if (accept) err_q <= 1'b0;
      else if (state == RDY_WAIT && state_nxt == RESP && !ready_ok) err_q <= 1'b1;
    end
`else
  logic unused_ry;
  assign unused_ry = flash_ry_by_i ^ (TIMEOUT_CYCLES == 0);
  assign err_q = 1'b0;
`endif
  always_ff @(posedge clk_i)
    if (reset_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (state_nxt != state || state == IDLE) ? '0 : cnt + 32'd1;
    end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept) state_nxt = wb_we_i ? WR_SETUP : RD;
      RD:       if (cnt == T_RD - 1) state_nxt = RESP;
      WR_SETUP: state_nxt = WR_PULSE;
      WR_PULSE: if (cnt == T_WP - 1) state_nxt = WR_HOLD;
`ifdef NOR_BUS_CTRL_RYBY_WAIT_EN
      WR_HOLD:  if (cnt == T_WH - 1) state_nxt = RDY_WAIT;
      RDY_WAIT: if (ready_ok || cnt == TIMEOUT_CYCLES - 1) state_nxt = RESP;
`else
      WR_HOLD:  if (cnt == T_WH - 1) state_nxt = RESP;
`endif
      default:  state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_i)
    if (reset_i) begin
      flash_adr_o <= '0;
      flash_dq_o  <= '0;
      wb_dat_o    <= '0;
      we_q        <= 1'b0;
    end else begin
      if (accept) begin
        flash_adr_o <= wb_adr_i;
        flash_dq_o  <= wb_dat_i;
        we_q        <= wb_we_i;
      end
      if (state == RD && state_nxt == RESP && !we_q) wb_dat_o <= flash_dq_i;
    end
  // Strobes decode purely from the state register, so wb inputs never reach the flash pins.
  always_comb begin
    flash_ce_n_o  = !(state inside {RD, WR_SETUP, WR_PULSE, WR_HOLD});
    flash_oe_n_o  = state != RD;
    flash_we_n_o  = state != WR_PULSE;
    flash_dq_oe_o = state inside {WR_SETUP, WR_PULSE, WR_HOLD};
    wb_stall_o    = state != IDLE;
    busy_o        = state != IDLE;
    wb_ack_o      = state == RESP && wb_cyc_i && !err_q;
    wb_err_o      = state == RESP && wb_cyc_i && err_q;
  end
endmodule
